// File: rtl/intensity_to_rgb.sv
// intensity_to_rgb: rebuilds colour from an equalised intensity.
// Each channel computes C' = min(MAXV, C*Ieq/I) with a serial restoring
// divider (one quotient bit per cycle). I==0 falls back to grey (C'=Ieq).
// Handshake: valid/ready on the input side and on the output side.

// Per-channel multiply + serial restoring divider.
// The channel loads P=C*Ieq in the MUL cycle, then steps once per DIV cycle.
// The low half of P and the growing quotient share one shift register: a
// dividend bit leaves at the top while a quotient bit enters at the bottom.
module intensity_to_rgb_chan #(
    parameter int WIDTH = 10
) (
    input  logic             gclk_i,
    input  logic             grst_n_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] ieq_i,
    input  logic [WIDTH-1:0] i_i,
    output logic [WIDTH-1:0] quo_nxt_o,
    output logic             sat_o
);
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   sh_q;
    logic               sat_q;
    logic [WIDTH:0]     shifted;
    logic               ge;

    assign prod = {{WIDTH{1'b0}}, c_i} * {{WIDTH{1'b0}}, ieq_i};

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    // When it fits, the true difference is below I, so a WIDTH-bit subtract
    // is exact.
    always_comb begin
        shifted = {rem_q, sh_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, i_i});
        rem_d   = ge ? (shifted[WIDTH-1:0] - i_i) : shifted[WIDTH-1:0];
    end

    assign quo_nxt_o = {sh_q[WIDTH-2:0], ge};
    assign sat_o     = sat_q;

    // Load the product in MUL, then advance one quotient bit per DIV cycle.
    // A quotient that would not fit in WIDTH bits is flagged as saturating;
    // otherwise the upper half of P is already below I and seeds the remainder.
    always_ff @(posedge gclk_i or negedge grst_n_i) begin
        if (!grst_n_i) begin
            rem_q <= '0;
            sh_q  <= '0;
            sat_q <= 1'b0;
        end else if (load_i) begin
            sat_q <= (prod >= {i_i, {WIDTH{1'b0}}});
            rem_q <= prod[2*WIDTH-1:WIDTH];
            sh_q  <= prod[WIDTH-1:0];
        end else if (step_i) begin
            rem_q <= rem_d;
            sh_q  <= {sh_q[WIDTH-2:0], ge};
        end
    end
endmodule

module intensity_to_rgb #(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}}
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [WIDTH-1:0] iR,
    input  logic [WIDTH-1:0] iG,
    input  logic [WIDTH-1:0] iB,
    input  logic [WIDTH-1:0] iIntensity,
    input  logic [WIDTH-1:0] iEqIntensity,
    input  logic             iValid,
    output logic             oInReady,
    output logic [WIDTH-1:0] oR,
    output logic [WIDTH-1:0] oG,
    output logic [WIDTH-1:0] oB,
    output logic             oValid,
    input  logic             iOutReady
);
    localparam int NCH = 3;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NCH-1:0][WIDTH-1:0]   col_q, col_d;
    logic [NCH-1:0][WIDTH-1:0]   res_q, res_d;
    logic [NCH-1:0][WIDTH-1:0]   quo_nxt;
    logic [NCH-1:0]              sat;
    logic [WIDTH-1:0]            i_q, i_d;
    logic [WIDTH-1:0]            ieq_q, ieq_d;
    logic                        zero_q, zero_d;
    logic                        accept, load, step;

    assign oInReady = (state_q == S_IDLE);
    assign oValid   = (state_q == S_DONE);
    assign accept   = iValid && oInReady;
    assign load     = (state_q == S_MUL);
    assign step     = (state_q == S_DIV);

    assign oR = res_q[0];
    assign oG = res_q[1];
    assign oB = res_q[2];

    // Channel 0/1/2 = R/G/B, all sharing I and Ieq.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        intensity_to_rgb_chan #(.WIDTH(WIDTH)) u_ch (
            .gclk_i    (iCLK),
            .grst_n_i  (iRST_N),
            .load_i    (load),
            .step_i    (step),
            .c_i       (col_q[c]),
            .ieq_i     (ieq_q),
            .i_i       (i_q),
            .quo_nxt_o (quo_nxt[c]),
            .sat_o     (sat[c])
        );
    end

    // Next-state logic: sequencing, input capture, and result selection.
    // The result takes the final quotient bit combinationally, so it is
    // registered on the same edge that leaves DIV.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        i_d     = i_q;
        ieq_d   = ieq_q;
        zero_d  = zero_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    col_d   = {iB, iG, iR};
                    i_d     = iIntensity;
                    ieq_d   = iEqIntensity;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                zero_d  = (i_q == '0);
                cnt_d   = CW'(WIDTH - 1);
                state_d = S_DIV;
            end
            S_DIV: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    for (int c = 0; c < NCH; c++) begin
                        res_d[c] = zero_q ? ieq_q : (sat[c] ? MAXV : quo_nxt[c]);
                    end
                end
            end
            S_DONE: begin
                if (iOutReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            i_q     <= '0;
            ieq_q   <= '0;
            zero_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            i_q     <= i_d;
            ieq_q   <= ieq_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_intensity_to_rgb.sv
// Directed bench for intensity_to_rgb (WIDTH=10).
module tb_intensity_to_rgb;
    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic [9:0] iR, iG, iB, iIntensity, iEqIntensity;
    logic       iValid, iOutReady;
    logic       oInReady, oValid;
    logic [9:0] oR, oG, oB;

    int pass_cnt  = 0;
    int check_cnt = 0;

    intensity_to_rgb #(.WIDTH(10)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iR(iR), .iG(iG), .iB(iB),
        .iIntensity(iIntensity), .iEqIntensity(iEqIntensity),
        .iValid(iValid), .oInReady(oInReady),
        .oR(oR), .oG(oG), .oB(oB), .oValid(oValid),
        .iOutReady(iOutReady)
    );

    always #5 iCLK = ~iCLK;

    // Offer one transaction from IDLE; lat = edges from accept to oValid (0 = timeout).
    task automatic run_txn(input logic [9:0] r, g, b, i, e, output int lat);
        for (int n = 0; n < 40 && !oInReady; n++) begin
            @(posedge iCLK); #1;
        end
        iR = r; iG = g; iB = b; iIntensity = i; iEqIntensity = e; iValid = 1'b1;
        @(posedge iCLK); #1;
        iValid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge iCLK); #1;
            if (oValid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic handshake(input string name);
        iOutReady = 1'b1;
        @(posedge iCLK); #1;
        iOutReady = 1'b0;
        check_cnt++;
        if (oValid !== 1'b0 || oInReady !== 1'b1)
            $display("FAIL %s_handshake: oValid=%b oInReady=%b want 0 1", name, oValid, oInReady);
        else pass_cnt++;
    endtask

    task automatic txn_check(input string name, input logic [9:0] r, g, b, i, e,
                             input logic [9:0] xr, xg, xb);
        int lat;
        run_txn(r, g, b, i, e, lat);
        check_cnt++;
        if (lat !== 11) $display("FAIL %s_latency: got %0d want 11", name, lat);
        else pass_cnt++;
        check_cnt++;
        if ({oR, oG, oB} !== {xr, xg, xb})
            $display("FAIL %s_rgb: got %0d,%0d,%0d want %0d,%0d,%0d", name, oR, oG, oB, xr, xg, xb);
        else pass_cnt++;
        handshake(name);
    endtask

    task automatic test_reset();
        iRST_N = 1'b0; iValid = 1'b0; iOutReady = 1'b0;
        iR = '0; iG = '0; iB = '0; iIntensity = '0; iEqIntensity = '0;
        #12;
        check_cnt++;
        if ({oR, oG, oB} !== 30'd0 || oValid !== 1'b0 || oInReady !== 1'b1)
            $display("FAIL reset: rgb=%0d,%0d,%0d v=%b rdy=%b want 0,0,0 0 1", oR, oG, oB, oValid, oInReady);
        else pass_cnt++;
        @(posedge iCLK); #1;
        iRST_N = 1'b1;
        @(posedge iCLK); #1;
        check_cnt++;
        if (oValid !== 1'b0 || oInReady !== 1'b1)
            $display("FAIL reset_release: v=%b rdy=%b want 0 1", oValid, oInReady);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        txn_check("scale_sat",  10'd400, 10'd600, 10'd200,  10'd450, 10'd900, 10'd800, 10'd1023, 10'd400);
        txn_check("trunc_sat",  10'd3,   10'd10,  10'd1023, 10'd7,   10'd10,  10'd4,   10'd14,   10'd1023);
        txn_check("zero_i",     10'd77,  10'd900, 10'd5,    10'd0,   10'd512, 10'd512, 10'd512,  10'd512);
        txn_check("passthru",   10'd123, 10'd456, 10'd789,  10'd300, 10'd300, 10'd123, 10'd456,  10'd789);
    endtask

    task automatic test_back_to_back();
        // Lowest intensity with full-scale Ieq: 1*1023/1 = 1023 exact, 0 stays 0.
        txn_check("b2b_a", 10'd1, 10'd0, 10'd2, 10'd1, 10'd1023, 10'd1023, 10'd0, 10'd1023);
        txn_check("b2b_b", 10'd1022, 10'd511, 10'd1, 10'd1023, 10'd1022, 10'd1021, 10'd510, 10'd0);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        run_txn(10'd400, 10'd600, 10'd200, 10'd450, 10'd900, lat);
        check_cnt++;
        if (lat !== 11) $display("FAIL bp_latency: got %0d want 11", lat);
        else pass_cnt++;
        iR = 10'd1; iG = 10'd2; iB = 10'd3; iIntensity = 10'd1; iEqIntensity = 10'd1;
        iValid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge iCLK); #1;
            if ({oR, oG, oB} !== {10'd800, 10'd1023, 10'd400} || oValid !== 1'b1 || oInReady !== 1'b0)
                bad++;
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
        else pass_cnt++;
        iValid = 1'b0;
        handshake("bp");
        check_cnt++;
        if ({oR, oG, oB} !== {10'd800, 10'd1023, 10'd400})
            $display("FAIL bp_after: got %0d,%0d,%0d want 800,1023,400", oR, oG, oB);
        else pass_cnt++;
        @(posedge iCLK); #1;
        check_cnt++;
        if (oValid !== 1'b0 || oInReady !== 1'b1)
            $display("FAIL bp_idle: v=%b rdy=%b want 0 1", oValid, oInReady);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_div();
        iR = 10'd500; iG = 10'd500; iB = 10'd500; iIntensity = 10'd9; iEqIntensity = 10'd3;
        iValid = 1'b1;
        @(posedge iCLK); #1;
        iValid = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge iCLK); #1;
        end
        iRST_N = 1'b0;
        #1;
        check_cnt++;
        if ({oR, oG, oB} !== 30'd0 || oValid !== 1'b0 || oInReady !== 1'b1)
            $display("FAIL mid_reset: rgb=%0d,%0d,%0d v=%b rdy=%b want 0,0,0 0 1", oR, oG, oB, oValid, oInReady);
        else pass_cnt++;
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iRST_N = 1'b1;
        @(posedge iCLK); #1;
        check_cnt++;
        if (oValid !== 1'b0) $display("FAIL mid_reset_nopartial: v=%b want 0", oValid);
        else pass_cnt++;
        txn_check("post_reset", 10'd3, 10'd10, 10'd1023, 10'd7, 10'd10, 10'd4, 10'd14, 10'd1023);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
